// File: rtl/dm_operand_loader_if.sv
// dm_operand_loader_if
//   Bundles the byte-stream handshake and the data-memory write port of the
//   boot-time operand loader.
//   master : the byte source / memory-side observer (bench or board glue)
//   slave  : the loader itself
//   in_valid, in_data  : byte stream into the loader
//   in_ready           : loader accepts a byte this cycle
//   dm_we, dm_addr,
//   dm_wdata           : data-memory write port driven by the loader
interface dm_operand_loader_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8
);
   logic                  in_valid;
   logic [7:0]            in_data;
   logic                  in_ready;
   logic                  dm_we;
   logic [ADDR_WIDTH-1:0] dm_addr;
   logic [DATA_WIDTH-1:0] dm_wdata;

   modport master (
      output in_valid,
      output in_data,
      input  in_ready,
      input  dm_we,
      input  dm_addr,
      input  dm_wdata
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready,
      output dm_we,
      output dm_addr,
      output dm_wdata
   );
endinterface

// File: rtl/dm_operand_loader.sv
// dm_operand_loader
//   Boot-time loader upstream of the mips core. Assembles little-endian
//   32-bit words from a byte stream, writes WORD_COUNT words to consecutive
//   data-memory word addresses starting at BASE_ADDR (wrapping modulo
//   2^ADDR_WIDTH), then releases the core reset HOLD_CYCLES cycles after the
//   last write.
//   clk        : rising-edge clock
//   asyn_n_rst : asynchronous active-low reset
//   start      : begin a load (honoured in IDLE and RUN only)
//   bus        : byte stream in / data-memory write out (slave side)
//   cpu_n_rst  : active-low reset to the core, low for the whole load
//   busy       : load in progress
//   done       : load complete, core running
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | after reset, waiting for the first start
// RECV   | accepting bytes of the current word (in_ready high)
// WRITE  | one-cycle dm_we pulse for the word just assembled
// HOLD   | all words written, core held in reset while counter runs
// RUN    | core released; start re-enters RECV for a new load
module dm_operand_loader #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 8,
   parameter int BASE_ADDR   = 0,
   parameter int WORD_COUNT  = 2,
   parameter int HOLD_CYCLES = 2
) (
   input  logic                      clk,
   input  logic                      asyn_n_rst,
   input  logic                      start,
   dm_operand_loader_if.slave        bus,
   output logic                      cpu_n_rst,
   output logic                      busy,
   output logic                      done
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_RECV  = 3'd1;
   localparam logic [2:0] S_WRITE = 3'd2;
   localparam logic [2:0] S_HOLD  = 3'd3;
   localparam logic [2:0] S_RUN   = 3'd4;

   localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

   localparam logic [ADDR_WIDTH-1:0] BASE_A   = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(WORD_COUNT - 1);
   localparam logic [HOLD_W-1:0]     HOLD_INIT = HOLD_W'(HOLD_CYCLES);
   localparam logic [HOLD_W-1:0]     HOLD_ONE  = HOLD_W'(1);

   logic [2:0]            state;
   logic [ADDR_WIDTH-1:0] word_idx;
   logic [1:0]            byte_idx;
   // Only the three lower bytes need storage; the top byte goes straight
   // from in_data into dm_wdata on the accepting edge.
   logic [23:0]           asm_word;
   logic [HOLD_W-1:0]     hold_cnt;

   logic                  dm_we_r;
   logic [ADDR_WIDTH-1:0] dm_addr_r;
   logic [DATA_WIDTH-1:0] dm_wdata_r;
   logic                  accept;

   // in_ready is a pure state decode so no input can reach it combinationally.
   assign bus.in_ready = (state == S_RECV);
   assign bus.dm_we    = dm_we_r;
   assign bus.dm_addr  = dm_addr_r;
   assign bus.dm_wdata = dm_wdata_r;

   assign accept = (state == S_RECV) && bus.in_valid;

   always_ff @(posedge clk or negedge asyn_n_rst) begin
      if (!asyn_n_rst) begin
         state      <= S_IDLE;
         word_idx   <= '0;
         byte_idx   <= '0;
         asm_word   <= '0;
         hold_cnt   <= '0;
         dm_we_r    <= 1'b0;
         dm_addr_r  <= '0;
         dm_wdata_r <= '0;
         cpu_n_rst  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state    <= S_RECV;
                  busy     <= 1'b1;
                  word_idx <= '0;
                  byte_idx <= '0;
               end
            end

            S_RECV: begin
               if (accept) begin
                  if (byte_idx == 2'd3) begin
                     state      <= S_WRITE;
                     dm_we_r    <= 1'b1;
                     dm_wdata_r <= DATA_WIDTH'({bus.in_data, asm_word});
                     // Natural truncation gives the modulo-2^ADDR_WIDTH wrap.
                     dm_addr_r  <= BASE_A + word_idx;
                     byte_idx   <= '0;
                  end else begin
                     case (byte_idx)
                        2'd0:    asm_word[7:0]   <= bus.in_data;
                        2'd1:    asm_word[15:8]  <= bus.in_data;
                        default: asm_word[23:16] <= bus.in_data;
                     endcase
                     byte_idx <= byte_idx + 2'd1;
                  end
               end
            end

            S_WRITE: begin
               dm_we_r <= 1'b0;
               if (word_idx == LAST_IDX) begin
                  state    <= S_HOLD;
                  hold_cnt <= HOLD_INIT;
               end else begin
                  state    <= S_RECV;
                  word_idx <= word_idx + 1'b1;
                  byte_idx <= '0;
               end
            end

            S_HOLD: begin
               // Counter starts at HOLD_CYCLES (>=1); the edge taking it to
               // zero is the release edge.
               if (hold_cnt <= HOLD_ONE) begin
                  hold_cnt  <= '0;
                  state     <= S_RUN;
                  cpu_n_rst <= 1'b1;
                  done      <= 1'b1;
                  busy      <= 1'b0;
               end else begin
                  hold_cnt <= hold_cnt - 1'b1;
               end
            end

            S_RUN: begin
               if (start) begin
                  state     <= S_RECV;
                  cpu_n_rst <= 1'b0;
                  done      <= 1'b0;
                  busy      <= 1'b1;
                  word_idx  <= '0;
                  byte_idx  <= '0;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dm_operand_loader.sv
// tb_dm_operand_loader
//   Directed plus randomized bench for dm_operand_loader. Two instances share
//   the byte stream: dut_a uses the default parameters, dut_b uses
//   BASE_ADDR=255 / HOLD_CYCLES=1 to exercise address wrap. Expected write
//   addresses, data, edges and release edge are computed from the byte list
//   and stall list with plain arithmetic.
module tb_dm_operand_loader;

   logic       clk = 1'b0;
   logic       asyn_n_rst;
   logic       start_a;
   logic       start_b;
   logic       in_valid;
   logic [7:0] in_data;
   logic       cpu_n_rst_a, busy_a, done_a;
   logic       cpu_n_rst_b, busy_b, done_b;

   int cyc = 0;
   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      int          edge_no;
      logic [7:0]  addr;
      logic [31:0] data;
   } wr_t;

   wr_t        wq_a[$];
   wr_t        wq_b[$];
   wr_t        mon_w;
   logic [7:0] stim[$];
   int         stl[$];

   dm_operand_loader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) ifa ();
   dm_operand_loader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) ifb ();

   assign ifa.in_valid = in_valid;
   assign ifa.in_data  = in_data;
   assign ifb.in_valid = in_valid;
   assign ifb.in_data  = in_data;

   dm_operand_loader dut_a (
      .clk        (clk),
      .asyn_n_rst (asyn_n_rst),
      .start      (start_a),
      .bus        (ifa),
      .cpu_n_rst  (cpu_n_rst_a),
      .busy       (busy_a),
      .done       (done_a)
   );

   dm_operand_loader #(
      .BASE_ADDR   (255),
      .WORD_COUNT  (2),
      .HOLD_CYCLES (1)
   ) dut_b (
      .clk        (clk),
      .asyn_n_rst (asyn_n_rst),
      .start      (start_b),
      .bus        (ifb),
      .cpu_n_rst  (cpu_n_rst_b),
      .busy       (busy_b),
      .done       (done_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record every write pulse with the index of the edge that raised it.
   always @(negedge clk) begin
      if (ifa.dm_we === 1'b1) begin
         mon_w.edge_no = cyc;
         mon_w.addr    = ifa.dm_addr;
         mon_w.data    = ifa.dm_wdata;
         wq_a.push_back(mon_w);
      end
      if (ifb.dm_we === 1'b1) begin
         mon_w.edge_no = cyc;
         mon_w.addr    = ifb.dm_addr;
         mon_w.data    = ifb.dm_wdata;
         wq_b.push_back(mon_w);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed no finish, expected finish before 100000");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      vectors++;
      assert (obs === exp_v) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   function automatic logic rdy(input bit sel_b);
      return sel_b ? ifb.in_ready : ifa.in_ready;
   endfunction
   function automatic logic cpu(input bit sel_b);
      return sel_b ? cpu_n_rst_b : cpu_n_rst_a;
   endfunction
   function automatic logic bsy(input bit sel_b);
      return sel_b ? busy_b : busy_a;
   endfunction
   function automatic logic dne(input bit sel_b);
      return sel_b ? done_b : done_a;
   endfunction

   task automatic set_start(input bit sel_b, input logic v);
      if (sel_b) start_b = v;
      else       start_a = v;
   endtask

   // Byte i of the stream is v[8i+7:8i]; stall_len idle cycles precede byte stall_idx.
   task automatic load_stim(input logic [63:0] v, input int stall_idx, input int stall_len);
      stim.delete();
      stl.delete();
      for (int i = 0; i < 8; i++) begin
         stim.push_back(v[8*i +: 8]);
         stl.push_back((i == stall_idx) ? stall_len : 0);
      end
   endtask

   task automatic load_random();
      logic [63:0] v;
      v = {$urandom, $urandom};
      load_stim(v, -1, 0);
      for (int i = 0; i < 8; i++)
         if ((i % 4) != 0) stl[i] = $urandom_range(0, 2);
   endtask

   task automatic check_result(input bit sel_b, input int e0, input int rel);
      int          base;
      int          hold;
      int          stall_sum;
      int          nq;
      logic [31:0] word;
      wr_t         w;
      base = sel_b ? 255 : 0;
      hold = sel_b ? 1 : 2;
      nq   = sel_b ? wq_b.size() : wq_a.size();
      chk("write_count", nq, 2);
      stall_sum = 0;
      for (int k = 0; k < 2; k++) begin
         word = {stim[4*k+3], stim[4*k+2], stim[4*k+1], stim[4*k]};
         for (int j = 0; j < 4; j++) stall_sum += stl[4*k+j];
         if ((sel_b ? wq_b.size() : wq_a.size()) > 0) begin
            w = sel_b ? wq_b.pop_front() : wq_a.pop_front();
            chk("write_addr", w.addr, (base + k) % 256);
            chk("write_data", w.data, word);
            chk("write_edge", w.edge_no, e0 + 5*k + 4 + stall_sum);
         end
      end
      chk("release_edge", rel, e0 + 5*2 + hold + stall_sum);
      chk("run_cpu_n_rst", cpu(sel_b), 1'b1);
      chk("run_done", dne(sel_b), 1'b1);
      chk("run_busy", bsy(sel_b), 1'b0);
      chk("run_ready", rdy(sel_b), 1'b0);
      wq_a.delete();
      wq_b.delete();
   endtask

   // Called at a negedge. Streams stim/stl into the selected instance and
   // waits for the core release.
   task automatic do_load(input bit sel_b, input int start_byte, input bit start_hold);
      int n;
      int e0;
      set_start(sel_b, 1'b1);
      e0 = cyc + 1;
      @(negedge clk);
      set_start(sel_b, 1'b0);
      chk("start_cpu_n_rst", cpu(sel_b), 1'b0);
      chk("start_done", dne(sel_b), 1'b0);
      chk("start_busy", bsy(sel_b), 1'b1);
      chk("start_ready", rdy(sel_b), 1'b1);
      for (int i = 0; i < stim.size(); i++) begin
         repeat (stl[i]) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(negedge clk);
         end
         in_valid = 1'b1;
         in_data  = stim[i];
         if (i == start_byte) set_start(sel_b, 1'b1);
         n = 0;
         while (rdy(sel_b) !== 1'b1 && n < 16) begin
            @(negedge clk);
            n++;
         end
         if (n >= 16) chk("ready_timeout", n, 0);
         @(negedge clk);
         set_start(sel_b, 1'b0);
      end
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      if (start_hold) begin
         @(negedge clk);
         chk("hold_cpu_n_rst", cpu(sel_b), 1'b0);
         chk("hold_busy", bsy(sel_b), 1'b1);
         set_start(sel_b, 1'b1);
         @(negedge clk);
         set_start(sel_b, 1'b0);
      end
      n = 0;
      while (cpu(sel_b) !== 1'b1 && n < 64) begin
         @(negedge clk);
         n++;
      end
      check_result(sel_b, e0, cyc);
      repeat (2) @(negedge clk);
      chk("run_stable_done", dne(sel_b), 1'b1);
   endtask

   task automatic chk_zero_a(input string tag);
      chk({tag, "_dm_we"}, ifa.dm_we, 1'b0);
      chk({tag, "_dm_addr"}, ifa.dm_addr, 8'h00);
      chk({tag, "_dm_wdata"}, ifa.dm_wdata, 32'h0);
      chk({tag, "_cpu_n_rst"}, cpu_n_rst_a, 1'b0);
      chk({tag, "_busy"}, busy_a, 1'b0);
      chk({tag, "_done"}, done_a, 1'b0);
      chk({tag, "_in_ready"}, ifa.in_ready, 1'b0);
   endtask

   initial begin
      asyn_n_rst = 1'b1;
      start_a    = 1'b0;
      start_b    = 1'b0;
      in_valid   = 1'b0;
      in_data    = 8'h00;

      // Reset with no clock edge in between.
      #1 asyn_n_rst = 1'b0;
      #1;
      chk_zero_a("reset");
      chk("reset_b_cpu_n_rst", cpu_n_rst_b, 1'b0);
      repeat (2) @(negedge clk);
      asyn_n_rst = 1'b1;
      @(negedge clk);

      // Default load: 5 and -4.
      load_stim({32'hFFFF_FFFC, 32'h0000_0005}, -1, 0);
      do_load(1'b0, -1, 1'b0);

      // Restart from RUN with a 3-cycle stall between bytes 2 and 3.
      load_stim({32'hFFFF_FFFC, 32'h0000_0005}, 2, 3);
      do_load(1'b0, -1, 1'b0);

      // start pulsed in RECV and in HOLD must be ignored; 217 and -128.
      load_stim({32'hFFFF_FF80, 32'h0000_00D9}, -1, 0);
      do_load(1'b0, 1, 1'b1);

      // Randomized loads with random in-word stalls.
      repeat (3) begin
         load_random();
         do_load(1'b0, -1, 1'b0);
      end

      // Address wrap on the second instance; dut_a sits in RUN and ignores bytes.
      chk("b_idle_no_write", wq_b.size(), 0);
      chk("b_idle_busy", busy_b, 1'b0);
      load_random();
      do_load(1'b1, -1, 1'b0);
      chk("a_run_no_write", wq_a.size(), 0);

      // Reset in the middle of word 0.
      wq_a.delete();
      set_start(1'b0, 1'b1);
      @(negedge clk);
      set_start(1'b0, 1'b0);
      in_valid = 1'b1;
      in_data  = 8'hAA;
      @(negedge clk);
      in_data  = 8'h55;
      @(negedge clk);
      in_valid = 1'b0;
      chk("midrst_busy_before", busy_a, 1'b1);
      #2 asyn_n_rst = 1'b0;
      #1;
      chk_zero_a("midrst");
      chk("midrst_b_dm_wdata", ifb.dm_wdata, 32'h0);
      @(negedge clk);
      asyn_n_rst = 1'b1;
      in_valid   = 1'b1;
      in_data    = 8'h77;
      repeat (4) @(negedge clk);
      in_valid   = 1'b0;
      chk("midrst_no_write", wq_a.size(), 0);
      chk("midrst_idle_busy", busy_a, 1'b0);
      chk("midrst_idle_ready", ifa.in_ready, 1'b0);
      load_random();
      do_load(1'b0, -1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
